// File: rtl/wall_game_sequencer.sv
// wall_game_sequencer: frame-level controller for the scrolling wall game.
// Derives a per-frame tick from the pixel counters, advances the scroll
// offsets and speed level, strobes the renderer's pattern LFSRs on every
// vertical wrap, and runs the hit / lives / game-over sequence and BCD score.
// Optional feature macro: HIGHSCORE_EN (best score retained across games).
module wall_game_sequencer #(
    parameter int H_LAST     = 1327,
    parameter int V_LAST     = 805,
    parameter int MAX_SPEED  = 5,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60
) (
    input  logic        clk75MHz,
    input  logic        nReset,
    input  logic [10:0] PixX,
    input  logic [9:0]  PixY,
    input  logic        Start,
    input  logic        Kollision,
    output logic [9:0]  ScrollY,
    output logic [10:0] ScrollX,
    output logic [2:0]  Speed,
    output logic        PatternStep,
    output logic        Freeze,
    output logic [1:0]  Lives,
    output logic [15:0] Punkte,
    output logic        GameOver,
    output logic [15:0] HighScore
);

    typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} stateT;

    stateT       stateReg, stateNext;
    logic        tickReg;
    logic        startPrevReg;
    logic        startEdge;
    logic        wrapReg;
    logic [7:0]  hitCntReg;
    logic [10:0] sumY;
    logic        carryY;
    logic [10:0] scrollXNext;
    logic        hitDone;
    logic [15:0] punkteInc;
    logic [3:0]  bcdCarry;

    assign startEdge   = Start & ~startPrevReg;
    assign sumY        = {1'b0, ScrollY} + {8'd0, Speed};
    assign carryY      = sumY[10];
    // Horizontal drift direction follows bit 8 of the vertical offset before update.
    assign scrollXNext = ScrollY[8] ? (ScrollX + {8'd0, Speed}) : (ScrollX - {8'd0, Speed});
    assign hitDone     = (stateReg == HIT) && tickReg && (hitCntReg == 8'(HIT_FRAMES - 1));

    // Ripple BCD incrementer: each digit rolls 9 -> 0 and carries into the next.
    assign bcdCarry[0] = 1'b1;
    for (genvar gi = 0; gi < 4; gi++) begin : gDigit
        logic [3:0] digit;
        assign digit = Punkte[4*gi +: 4];
        assign punkteInc[4*gi +: 4] = bcdCarry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
        if (gi < 3) begin : gCarry
            assign bcdCarry[gi+1] = bcdCarry[gi] && (digit == 4'd9);
        end
    end

    // Frame tick (cycle after the last pixel) and Start edge detector.
    always_ff @(posedge clk75MHz or negedge nReset) begin
        if (!nReset) begin
            tickReg      <= 1'b0;
            startPrevReg <= 1'b0;
        end else begin
            tickReg      <= (PixX == 11'(H_LAST)) && (PixY == 10'(V_LAST));
            startPrevReg <= Start;
        end
    end

    // FSM state register.
    always_ff @(posedge clk75MHz or negedge nReset) begin
        if (!nReset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state logic; a collision in RUN wins over everything else.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (startEdge) stateNext = RUN;
            RUN:     if (Kollision) stateNext = HIT;
            HIT:     if (hitDone)   stateNext = (Lives == 2'd0) ? OVER : RUN;
            OVER:    if (startEdge) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs; PatternStep fires in the tick cycle whose vertical add wraps.
    always_comb begin
        Freeze      = (stateReg == HIT);
        GameOver    = (stateReg == OVER);
        PatternStep = (stateReg == RUN) && tickReg && !Kollision && carryY;
    end

    // Scroll offsets, speed, lives, score and HIT frame counter.
    always_ff @(posedge clk75MHz or negedge nReset) begin
        if (!nReset) begin
            ScrollY   <= 10'd0;
            ScrollX   <= 11'd0;
            Speed     <= 3'd1;
            Lives     <= 2'(LIVES);
            Punkte    <= 16'h0000;
            wrapReg   <= 1'b0;
            hitCntReg <= 8'd0;
        end else begin
            case (stateReg)
                IDLE, OVER: begin
                    if (startEdge) begin
                        ScrollY <= 10'd0;
                        ScrollX <= 11'd0;
                        Speed   <= 3'd1;
                        Lives   <= 2'(LIVES);
                        Punkte  <= 16'h0000;
                        wrapReg <= 1'b0;
                    end
                end
                RUN: begin
                    if (Kollision) begin
                        Lives     <= Lives - 2'd1;
                        hitCntReg <= 8'd0;
                    end else if (tickReg) begin
                        ScrollY <= sumY[9:0];
                        ScrollX <= scrollXNext;
                        if (Punkte != 16'h9999) begin
                            Punkte <= punkteInc;
                        end
                        if (carryY) begin
                            wrapReg <= ~wrapReg;
                            if (wrapReg && (Speed < 3'(MAX_SPEED))) begin
                                Speed <= Speed + 3'd1;
                            end
                        end
                    end
                end
                HIT: begin
                    if (tickReg) begin
                        if (hitDone) begin
                            if (Lives != 2'd0) begin
                                ScrollY <= 10'd0;
                                ScrollX <= 11'd0;
                                Speed   <= 3'd1;
                                wrapReg <= 1'b0;
                            end
                        end else begin
                            hitCntReg <= hitCntReg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HIGHSCORE_EN
    logic [15:0] highScoreReg;

    // Capture the final score on entry to OVER when it beats the stored best.
    always_ff @(posedge clk75MHz or negedge nReset) begin
        if (!nReset) begin
            highScoreReg <= 16'h0000;
        end else if ((stateReg != OVER) && (stateNext == OVER) && (Punkte > highScoreReg)) begin
            highScoreReg <= Punkte;
        end
    end

    assign HighScore = highScoreReg;
`else
    assign HighScore = 16'h0000;
`endif

endmodule
